// File: rtl/bsg_wormhole_router_packet_framer.sv
// Wormhole packet framer: one header flit {user,len,cord}, then len body flits.
// Define BSG_WORMHOLE_FRAMER_OUT_REG_EN to drive the link from a 2-entry registered buffer.
module bsg_wormhole_router_packet_framer #(
  parameter int unsigned flit_width_p = 32,
  parameter int unsigned cord_width_p = 5,
  parameter int unsigned len_width_p  = 4
) (
  input  logic                                           clk_i,
  input  logic                                           reset_n_i,
  input  logic                                           hdr_v_i,
  input  logic [cord_width_p-1:0]                        hdr_cord_i,
  input  logic [len_width_p-1:0]                         hdr_len_i,
  input  logic [flit_width_p-cord_width_p-len_width_p-1:0] hdr_user_i,
  output logic                                           hdr_ready_o,
  input  logic                                           data_v_i,
  input  logic [flit_width_p-1:0]                        data_i,
  output logic                                           data_ready_o,
  output logic                                           link_v_o,
  output logic [flit_width_p-1:0]                        link_data_o,
  input  logic                                           link_ready_i,
  output logic                                           link_first_o,
  output logic                                           link_last_o
);

  typedef enum logic {ST_HDR, ST_BODY} state_e;

  state_e                    state_q, state_d;
  logic [len_width_p-1:0]    cnt_q, cnt_d;
  logic                      src_v_c, src_first_c, src_last_c;
  logic [flit_width_p-1:0]   src_data_c;
  logic                      sink_ready_c;

  // Framing FSM: selects header or body source and counts body flits down.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hdr_ready_o  = 1'b0;
    data_ready_o = 1'b0;
    src_v_c      = 1'b0;
    src_data_c   = '0;
    src_first_c  = 1'b0;
    src_last_c   = 1'b0;
    case (state_q)
      ST_HDR: begin
        src_v_c     = hdr_v_i;
        src_data_c  = {hdr_user_i, hdr_len_i, hdr_cord_i};
        src_first_c = 1'b1;
        src_last_c  = (hdr_len_i == '0);
        hdr_ready_o = sink_ready_c;
        if (hdr_v_i && sink_ready_c && (hdr_len_i != '0)) begin
          cnt_d   = hdr_len_i;
          state_d = ST_BODY;
        end
      end
      ST_BODY: begin
        src_v_c      = data_v_i;
        src_data_c   = data_i;
        src_last_c   = (cnt_q == len_width_p'(1));
        data_ready_o = sink_ready_c;
        if (data_v_i && sink_ready_c) begin
          cnt_d = cnt_q - len_width_p'(1);
          if (cnt_q == len_width_p'(1)) state_d = ST_HDR;
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_HDR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BSG_WORMHOLE_FRAMER_OUT_REG_EN
  localparam int unsigned EntryW = flit_width_p + 2;

  logic [EntryW-1:0] mem_q [2];
  logic              wptr_q, rptr_q;
  logic [1:0]        used_q;
  logic              enq_c, deq_c;

  // Upstream sees only buffer occupancy, so link_ready_i never reaches the ready outputs.
  assign sink_ready_c = reset_n_i & (used_q != 2'd2);
  assign enq_c        = src_v_c & sink_ready_c;
  assign link_v_o     = reset_n_i & (used_q != 2'd0);
  assign deq_c        = link_v_o & link_ready_i;
  assign {link_data_o, link_first_o, link_last_o} = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      used_q <= 2'd0;
    end else begin
      if (enq_c) begin
        mem_q[wptr_q] <= {src_data_c, src_first_c, src_last_c};
        wptr_q        <= ~wptr_q;
      end
      if (deq_c) rptr_q <= ~rptr_q;
      used_q <= used_q + 2'(enq_c) - 2'(deq_c);
    end
  end
`else
  // Pass-through: valid is gated only by reset, never by link_ready_i.
  assign sink_ready_c = reset_n_i & link_ready_i;
  assign link_v_o     = reset_n_i & src_v_c;
  assign link_data_o  = src_data_c;
  assign link_first_o = src_first_c;
  assign link_last_o  = src_last_c;
`endif

endmodule
